// File: rtl/rf_pkg.sv
// Shared types and constants for the rfile write-back scheduler.
package rf_pkg;

  localparam int unsigned XLEN           = 64;
  localparam int unsigned XWDT           = 6;
  localparam int unsigned XN             = 64;
  localparam int unsigned PARALLELACCESS = 3;
  localparam int unsigned NREQ           = 4;
  localparam int unsigned RRW            = $clog2(NREQ);
  localparam int unsigned CNTW           = $clog2(PARALLELACCESS + 1);

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;
  localparam logic [1:0] SZ_D = 2'b11;

  typedef struct packed {
    logic [XWDT-1:0] rd;
    logic [XLEN-1:0] data;
    logic [1:0]      size;
    logic [2:0]      pos;
  } wb_req_t;

  typedef struct packed {
    logic [XWDT-1:0] wr_idx;
    logic [XLEN-1:0] wr_data;
    logic [1:0]      wr_size;
    logic [2:0]      wr_pos;
  } wb_lane_t;

  // (base + off) mod NREQ, for base < NREQ and off <= NREQ
  function automatic logic [RRW-1:0] rr_add(logic [RRW-1:0] base, int unsigned off);
    logic [RRW:0] s;
    s = {1'b0, base} + (RRW+1)'(off);
    if (s >= (RRW+1)'(NREQ)) s = s - (RRW+1)'(NREQ);
    return s[RRW-1:0];
  endfunction

  function automatic wb_lane_t to_lane(wb_req_t r);
    return '{wr_idx: r.rd, wr_data: r.data, wr_size: r.size, wr_pos: r.pos};
  endfunction

endpackage

// File: rtl/rf_wb_sched_if.sv
// Requester, issue-claim and rfile write-lane signals of the write-back scheduler.
interface rf_wb_sched_if;
  import rf_pkg::*;

  logic [NREQ-1:0]                      req_valid;
  logic [NREQ-1:0]                      req_ready;
  logic [NREQ-1:0][XWDT-1:0]            req_rd;
  logic [NREQ-1:0][XLEN-1:0]            req_data;
  logic [NREQ-1:0][1:0]                 req_size;
  logic [NREQ-1:0][2:0]                 req_pos;
  logic                                 claim_valid;
  logic [XWDT-1:0]                      claim_rd;
  logic                                 claim_ready;
  logic [XN-1:0]                        busy;
  logic                                 rf_we;
  logic [PARALLELACCESS-1:0][XWDT-1:0]  rf_rwrites;
  logic [PARALLELACCESS-1:0][XLEN-1:0]  rf_rins;
  logic [PARALLELACCESS-1:0][1:0]       rf_rwsizes;
  logic [PARALLELACCESS-1:0][2:0]       rf_rwposs;

  modport master (
    output req_valid, req_rd, req_data, req_size, req_pos, claim_valid, claim_rd,
    input  req_ready, claim_ready, busy, rf_we, rf_rwrites, rf_rins, rf_rwsizes, rf_rwposs
  );

  modport slave (
    input  req_valid, req_rd, req_data, req_size, req_pos, claim_valid, claim_rd,
    output req_ready, claim_ready, busy, rf_we, rf_rwrites, rf_rins, rf_rwsizes, rf_rwposs
  );

endinterface

// File: rtl/rr_multi_grant.sv
// Round-robin multi-grant: up to PARALLELACCESS grants per cycle, skipping duplicate rds.
module rr_multi_grant
  import rf_pkg::*;
(
  input  logic [NREQ-1:0]                     i_valid,
  input  logic [NREQ-1:0][XWDT-1:0]           i_rd,
  input  logic [RRW-1:0]                      i_rr,
  output logic [NREQ-1:0]                     o_grant,
  output logic [PARALLELACCESS-1:0][RRW-1:0]  o_lane_map,
  output logic [PARALLELACCESS-1:0]           o_lane_vld,
  output logic [RRW-1:0]                      o_rr_next
);

  logic [CNTW-1:0] w_cnt;
  logic [RRW-1:0]  w_idx;
  logic            w_hit;

  // Scan order rr, rr+1, ...; grant k lands on lane k
  always_comb begin
    o_grant    = '0;
    o_lane_map = '0;
    o_lane_vld = '0;
    o_rr_next  = i_rr;
    w_cnt      = '0;
    w_idx      = '0;
    w_hit      = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      w_idx = rr_add(i_rr, k);
      w_hit = 1'b0;
      for (int j = 0; j < PARALLELACCESS; j++) begin
        if (o_lane_vld[j] && (i_rd[o_lane_map[j]] == i_rd[w_idx])) w_hit = 1'b1;
      end
      if (i_valid[w_idx] && !w_hit && (w_cnt < CNTW'(PARALLELACCESS))) begin
        o_grant[w_idx]    = 1'b1;
        o_lane_map[w_cnt] = w_idx;
        o_lane_vld[w_cnt] = 1'b1;
        w_cnt             = w_cnt + CNTW'(1);
        o_rr_next         = rr_add(w_idx, 1);
      end
    end
  end

endmodule

// File: rtl/rf_wb_sched.sv
// Write-back scheduler: registered rfile lane drive, round-robin pointer and busy scoreboard.
module rf_wb_sched
  import rf_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  rf_wb_sched_if.slave bus
);

  logic [NREQ-1:0]                     w_grant;
  logic [PARALLELACCESS-1:0][RRW-1:0]  w_lane_map;
  logic [PARALLELACCESS-1:0]           w_lane_vld;
  logic [RRW-1:0]                      w_rr_next;
  wb_req_t  [NREQ-1:0]                 w_req;
  wb_lane_t [PARALLELACCESS-1:0]       w_lane_nxt;
  logic [XN-1:0]                       w_busy_nxt;
  logic                                w_claim_ok;

  logic [RRW-1:0]                      r_rr;
  logic [XN-1:0]                       r_busy;
  logic                                r_we;
  wb_lane_t [PARALLELACCESS-1:0]       r_lane;

  rr_multi_grant u_grant (
    .i_valid    (bus.req_valid),
    .i_rd       (bus.req_rd),
    .i_rr       (r_rr),
    .o_grant    (w_grant),
    .o_lane_map (w_lane_map),
    .o_lane_vld (w_lane_vld),
    .o_rr_next  (w_rr_next)
  );

  for (genvar g = 0; g < NREQ; g++) begin : g_req
    assign w_req[g] = '{rd: bus.req_rd[g], data: bus.req_data[g],
                        size: bus.req_size[g], pos: bus.req_pos[g]};
  end

  // Idle lanes mirror lane 0 so the shared write enable stays harmless
  for (genvar g = 0; g < PARALLELACCESS; g++) begin : g_lane
    assign w_lane_nxt[g] = to_lane(w_lane_vld[g] ? w_req[w_lane_map[g]] : w_req[w_lane_map[0]]);
    assign bus.rf_rwrites[g] = r_lane[g].wr_idx;
    assign bus.rf_rins[g]    = r_lane[g].wr_data;
    assign bus.rf_rwsizes[g] = r_lane[g].wr_size;
    assign bus.rf_rwposs[g]  = r_lane[g].wr_pos;
  end

  assign w_claim_ok      = !rst && !r_busy[bus.claim_rd];
  assign bus.claim_ready = w_claim_ok;
  assign bus.req_ready   = rst ? '0 : w_grant;
  assign bus.busy        = r_busy;
  assign bus.rf_we       = r_we;

  // Clear on the committing edge first, so a same-edge claim wins
  always_comb begin
    w_busy_nxt = r_busy;
    if (r_we) begin
      for (int k = 0; k < PARALLELACCESS; k++) w_busy_nxt[r_lane[k].wr_idx] = 1'b0;
    end
    if (bus.claim_valid && w_claim_ok) w_busy_nxt[bus.claim_rd] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rr   <= '0;
      r_busy <= '0;
      r_we   <= 1'b0;
      r_lane <= '0;
    end else begin
      r_rr   <= w_rr_next;
      r_busy <= w_busy_nxt;
      r_we   <= |w_grant;
      if (|w_grant) r_lane <= w_lane_nxt;
    end
  end

endmodule

// File: tb/tb_rf_wb_sched.sv
// Directed and randomized check of rf_wb_sched against a queue-based reference model.
module tb_rf_wb_sched;
  import rf_pkg::*;

  logic clk = 1'b0;
  logic rst;

  rf_wb_sched_if bus ();

  rf_wb_sched dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_mis = 0;

  // Reference state: pointer, pending mask, last registered lane contents
  int              m_rr;
  logic [XN-1:0]   m_busy;
  logic            m_we;
  logic [XWDT-1:0] m_idx  [PARALLELACCESS];
  logic [XLEN-1:0] m_data [PARALLELACCESS];
  logic [1:0]      m_size [PARALLELACCESS];
  logic [2:0]      m_pos  [PARALLELACCESS];
  logic [NREQ-1:0] g_mask;
  int              g_order[$];
  logic [NREQ-1:0] m_last_grant;

  task automatic check(string tag, logic [127:0] obs, logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic void compute_grants();
    int rds[$];
    g_mask = '0;
    g_order.delete();
    for (int k = 0; k < NREQ; k++) begin
      int i;
      bit dup;
      i = (m_rr + k) % NREQ;
      dup = 0;
      foreach (rds[j]) if (rds[j] == int'(bus.req_rd[i])) dup = 1;
      if (bus.req_valid[i] && !dup && g_order.size() < PARALLELACCESS) begin
        g_mask[i] = 1'b1;
        g_order.push_back(i);
        rds.push_back(int'(bus.req_rd[i]));
      end
    end
  endfunction

  // One clock: inputs already driven after a falling edge
  task automatic step();
    logic          exp_cr;
    logic [XN-1:0] nb;
    int            s;
    #1;
    compute_grants();
    exp_cr = !rst && !m_busy[bus.claim_rd];
    check("req_ready", 128'(bus.req_ready), rst ? 128'(0) : 128'(g_mask));
    check("claim_ready", 128'(bus.claim_ready), 128'(exp_cr));
    m_last_grant = rst ? '0 : g_mask;
    @(posedge clk);
    if (rst) begin
      m_rr = 0; m_busy = '0; m_we = 1'b0;
      for (int k = 0; k < PARALLELACCESS; k++) begin
        m_idx[k] = '0; m_data[k] = '0; m_size[k] = '0; m_pos[k] = '0;
      end
    end else begin
      nb = m_busy;
      if (m_we) for (int k = 0; k < PARALLELACCESS; k++) nb[m_idx[k]] = 1'b0;
      if (bus.claim_valid && exp_cr) nb[bus.claim_rd] = 1'b1;
      m_busy = nb;
      m_we = (g_order.size() > 0);
      if (m_we) begin
        for (int k = 0; k < PARALLELACCESS; k++) begin
          s = (k < g_order.size()) ? g_order[k] : g_order[0];
          m_idx[k] = bus.req_rd[s]; m_data[k] = bus.req_data[s];
          m_size[k] = bus.req_size[s]; m_pos[k] = bus.req_pos[s];
        end
        m_rr = (g_order[g_order.size()-1] + 1) % NREQ;
      end
    end
    #1;
    check("rf_we", 128'(bus.rf_we), 128'(m_we));
    check("busy", 128'(bus.busy), 128'(m_busy));
    for (int k = 0; k < PARALLELACCESS; k++)
      check($sformatf("lane%0d", k),
            128'({bus.rf_rwrites[k], bus.rf_rins[k], bus.rf_rwsizes[k], bus.rf_rwposs[k]}),
            128'({m_idx[k], m_data[k], m_size[k], m_pos[k]}));
    @(negedge clk);
  endtask

  task automatic clr_in();
    bus.req_valid = '0; bus.req_rd = '0; bus.req_data = '0;
    bus.req_size = '0; bus.req_pos = '0;
    bus.claim_valid = 1'b0; bus.claim_rd = '0;
  endtask

  task automatic set_req(int i, int rd, logic [XLEN-1:0] d, logic [1:0] sz, int pos);
    bus.req_valid[i] = 1'b1; bus.req_rd[i] = XWDT'(rd); bus.req_data[i] = d;
    bus.req_size[i] = sz; bus.req_pos[i] = 3'(pos);
  endtask

  task automatic claim(int rd);
    bus.claim_valid = 1'b1; bus.claim_rd = XWDT'(rd);
  endtask

  initial begin
    m_rr = 0; m_busy = '0; m_we = 1'b0; m_last_grant = '0;
    for (int k = 0; k < PARALLELACCESS; k++) begin
      m_idx[k] = '0; m_data[k] = '0; m_size[k] = '0; m_pos[k] = '0;
    end
    rst = 1'b1; clr_in();
    step(); step();
    rst = 1'b0;

    // single write with busy clear
    claim(5); step(); clr_in();
    set_req(2, 5, 64'hDEAD, SZ_D, 0); step(); clr_in();
    step(); step();

    // contention from rr = 0
    rst = 1'b1; step(); rst = 1'b0;
    for (int i = 0; i < NREQ; i++) set_req(i, 10 + i, 64'(100 + i), SZ_D, 0);
    step();
    bus.req_valid[2:0] = '0; step(); clr_in();
    step();

    // same-rd conflict
    set_req(0, 7, 64'h70, SZ_D, 0); set_req(1, 7, 64'h71, SZ_D, 0); step();
    bus.req_valid[0] = 1'b0; step(); clr_in();
    step();

    // scoreboard: claim, WAW stall, claim during commit
    claim(9); step();
    step(); clr_in();
    set_req(0, 9, 64'h99, SZ_D, 0); step(); clr_in();
    claim(9); step(); clr_in();
    step();

    // sub-word write
    set_req(1, 4, 64'hAB, SZ_B, 3); step(); clr_in();
    step();

    // reset the cycle after acceptance
    claim(20); step(); clr_in();
    set_req(0, 20, 64'h2020, SZ_W, 4); step(); clr_in();
    rst = 1'b1; step(); rst = 1'b0;
    step();

    // randomized traffic with hold-until-accepted requesters
    for (int n = 0; n < 600; n++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!(bus.req_valid[i] && !m_last_grant[i])) begin
          bus.req_valid[i] = ($urandom_range(0, 3) != 0);
          bus.req_rd[i]    = XWDT'($urandom_range(0, 7));
          bus.req_data[i]  = {$urandom, $urandom};
          bus.req_size[i]  = 2'($urandom_range(0, 3));
          bus.req_pos[i]   = 3'($urandom_range(0, 7));
        end
      end
      bus.claim_valid = ($urandom_range(0, 1) == 1);
      bus.claim_rd    = XWDT'($urandom_range(0, 7));
      rst = ($urandom_range(0, 49) == 0);
      step();
    end
    rst = 1'b0; clr_in(); step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
